// File: rtl/video_pkg.sv
// Shared types and defaults for the triple-buffered frame-bank scheduler.
package video_pkg;

    typedef enum logic [1:0] {FREE, WRITING, READY, READING} bank_state_e;

    typedef logic [1:0] bank_idx_t;

    localparam int unsigned DEF_FB_DEPTH = 19200;
    localparam int unsigned DEF_ADDR_W   = 15;
    localparam int unsigned NUM_BANKS    = 3;

endpackage

// File: rtl/free_bank_pick.sv
// Picks the lowest-index bank whose FREE bit is set.
module free_bank_pick
    import video_pkg::*;
(
    input  logic [2:0] free_mask_i,
    output bank_idx_t  idx_o
);

    always_comb begin
        idx_o = 2'd0;
        if (free_mask_i[0]) begin
            idx_o = 2'd0;
        end else if (free_mask_i[1]) begin
            idx_o = 2'd1;
        end else if (free_mask_i[2]) begin
            idx_o = 2'd2;
        end
    end

endmodule

// File: rtl/frame_bank_scheduler.sv
// Three-bank frame scheduler between a downscaler writer and a pixel_transfer reader.
module frame_bank_scheduler
    import video_pkg::*;
#(
    parameter int unsigned FB_DEPTH = DEF_FB_DEPTH,
    parameter int unsigned ADDR_W   = DEF_ADDR_W,
    parameter int unsigned DATA_W   = 4,
    parameter int unsigned CNT_W    = 8
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              wr_sof_i,
    input  logic              wr_eof_i,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    output logic              fb_wr_o,
    output logic [ADDR_W+1:0] fb_wr_addr_o,
    output logic [DATA_W-1:0] fb_wr_data_o,
    input  logic              rd_req_i,
    output logic              rd_ack_o,
    output logic              rd_valid_o,
    output logic              rd_new_o,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [ADDR_W+1:0] fb_rd_addr_o,
    output logic [1:0]        wr_bank_o,
    output logic [1:0]        rd_bank_o,
    output logic [CNT_W-1:0]  drop_cnt_o,
    output logic [CNT_W-1:0]  repeat_cnt_o,
    output logic              addr_err_o
);

    bank_state_e bank_q   [NUM_BANKS];
    bank_state_e bank_mid [NUM_BANKS];
    bank_state_e bank_d   [NUM_BANKS];

    bank_idx_t  wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
    bank_idx_t  w_idx, r_idx, pick_idx;
    logic       found_w, found_r, drop_inc, repeat_inc;
    logic       rd_ack_q, rd_ack_d, rd_new_q, rd_new_d;
    logic       writing_d, in_range, wr_ok, err_set;
    logic [2:0] free_mask;
    logic [CNT_W-1:0] drop_q, repeat_q;
    logic             fb_wr_q, addr_err_q;
    logic [ADDR_W+1:0] fb_wr_addr_q;
    logic [DATA_W-1:0] fb_wr_data_q;

    // Events are applied in order eof -> rd_req -> sof-abort; the sof allocation follows below.
    always_comb begin
        bank_mid   = bank_q;
        rd_bank_d  = rd_bank_q;
        rd_ack_d   = 1'b0;
        rd_new_d   = rd_new_q;
        drop_inc   = 1'b0;
        repeat_inc = 1'b0;
        found_w    = 1'b0;
        found_r    = 1'b0;
        w_idx      = 2'd0;
        r_idx      = 2'd0;
        free_mask  = 3'b000;

        for (int i = 0; i < NUM_BANKS; i++) begin
            if (bank_mid[i] == WRITING) begin
                found_w = 1'b1;
                w_idx   = bank_idx_t'(i);
            end
        end
        if (wr_eof_i && found_w) begin
            for (int i = 0; i < NUM_BANKS; i++) begin
                if (bank_mid[i] == READY) begin
                    bank_mid[i] = FREE;
                    drop_inc    = 1'b1;
                end
            end
            bank_mid[w_idx] = READY;
        end

        for (int i = 0; i < NUM_BANKS; i++) begin
            if (bank_mid[i] == READY) begin
                found_r = 1'b1;
                r_idx   = bank_idx_t'(i);
            end
        end
        if (rd_req_i) begin
            rd_ack_d = 1'b1;
            if (found_r) begin
                for (int i = 0; i < NUM_BANKS; i++) begin
                    if (bank_mid[i] == READING) bank_mid[i] = FREE;
                end
                bank_mid[r_idx] = READING;
                rd_bank_d       = r_idx;
                rd_new_d        = 1'b1;
            end else begin
                rd_new_d = 1'b0;
                for (int i = 0; i < NUM_BANKS; i++) begin
                    if (bank_mid[i] == READING) repeat_inc = 1'b1;
                end
            end
        end

        if (wr_sof_i) begin
            for (int i = 0; i < NUM_BANKS; i++) begin
                if (bank_mid[i] == WRITING) bank_mid[i] = FREE;
            end
        end

        for (int i = 0; i < NUM_BANKS; i++) begin
            free_mask[i] = (bank_mid[i] == FREE);
        end
    end

    free_bank_pick u_free_bank_pick (
        .free_mask_i (free_mask),
        .idx_o       (pick_idx)
    );

    // Writes use the post-event state so a pixel in the sof cycle lands in the new bank.
    always_comb begin
        bank_d    = bank_mid;
        wr_bank_d = wr_bank_q;
        writing_d = 1'b0;
        if (wr_sof_i) begin
            bank_d[pick_idx] = WRITING;
            wr_bank_d        = pick_idx;
        end
        for (int i = 0; i < NUM_BANKS; i++) begin
            if (bank_d[i] == WRITING) writing_d = 1'b1;
        end
        in_range = (32'(wr_addr_i) < FB_DEPTH);
        wr_ok    = wr_en_i && writing_d && in_range;
        err_set  = wr_en_i && writing_d && !in_range;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < NUM_BANKS; i++) bank_q[i] <= FREE;
            wr_bank_q    <= 2'd0;
            rd_bank_q    <= 2'd0;
            rd_ack_q     <= 1'b0;
            rd_new_q     <= 1'b0;
            drop_q       <= '0;
            repeat_q     <= '0;
            fb_wr_q      <= 1'b0;
            fb_wr_addr_q <= '0;
            fb_wr_data_q <= '0;
            addr_err_q   <= 1'b0;
        end else begin
            bank_q       <= bank_d;
            wr_bank_q    <= wr_bank_d;
            rd_bank_q    <= rd_bank_d;
            rd_ack_q     <= rd_ack_d;
            rd_new_q     <= rd_new_d;
            if (drop_inc && drop_q != '1) drop_q <= drop_q + CNT_W'(1);
            if (repeat_inc && repeat_q != '1) repeat_q <= repeat_q + CNT_W'(1);
            fb_wr_q      <= wr_ok;
            fb_wr_addr_q <= {wr_bank_d, wr_addr_i};
            fb_wr_data_q <= wr_data_i;
            if (err_set) addr_err_q <= 1'b1;
        end
    end

    always_comb begin
        rd_valid_o = 1'b0;
        for (int i = 0; i < NUM_BANKS; i++) begin
            if (bank_q[i] == READING) rd_valid_o = 1'b1;
        end
    end

    assign fb_rd_addr_o = {rd_bank_q, rd_addr_i};
    assign fb_wr_o      = fb_wr_q;
    assign fb_wr_addr_o = fb_wr_addr_q;
    assign fb_wr_data_o = fb_wr_data_q;
    assign rd_ack_o     = rd_ack_q;
    assign rd_new_o     = rd_new_q;
    assign wr_bank_o    = wr_bank_q;
    assign rd_bank_o    = rd_bank_q;
    assign drop_cnt_o   = drop_q;
    assign repeat_cnt_o = repeat_q;
    assign addr_err_o   = addr_err_q;

endmodule

// File: tb/tb_frame_bank_scheduler.sv
// Scoreboard bench for frame_bank_scheduler: writes and read acks are checked by a monitor.
module tb_frame_bank_scheduler;

    localparam int ADDR_W = 15;
    localparam int DATA_W = 4;
    localparam int CNT_W  = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              wr_sof = 1'b0, wr_eof = 1'b0, wr_en = 1'b0, rd_req = 1'b0;
    logic [ADDR_W-1:0] wr_addr = '0, rd_addr = '0;
    logic [DATA_W-1:0] wr_data = '0;
    logic              fb_wr, rd_ack, rd_valid, rd_new, addr_err;
    logic [ADDR_W+1:0] fb_wr_addr, fb_rd_addr;
    logic [DATA_W-1:0] fb_wr_data;
    logic [1:0]        wr_bank, rd_bank;
    logic [CNT_W-1:0]  drop_cnt, repeat_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    // Expected write: {bank, addr, data}; expected ack: {rd_bank, rd_new, rd_valid, repeat_cnt}.
    logic [20:0] wr_q [$];
    logic [11:0] ack_q [$];
    logic [20:0] wexp;
    logic [11:0] aexp;

    frame_bank_scheduler dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .wr_sof_i     (wr_sof),
        .wr_eof_i     (wr_eof),
        .wr_en_i      (wr_en),
        .wr_addr_i    (wr_addr),
        .wr_data_i    (wr_data),
        .fb_wr_o      (fb_wr),
        .fb_wr_addr_o (fb_wr_addr),
        .fb_wr_data_o (fb_wr_data),
        .rd_req_i     (rd_req),
        .rd_ack_o     (rd_ack),
        .rd_valid_o   (rd_valid),
        .rd_new_o     (rd_new),
        .rd_addr_i    (rd_addr),
        .fb_rd_addr_o (fb_rd_addr),
        .wr_bank_o    (wr_bank),
        .rd_bank_o    (rd_bank),
        .drop_cnt_o   (drop_cnt),
        .repeat_cnt_o (repeat_cnt),
        .addr_err_o   (addr_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (fb_wr) begin
            n_tests++;
            if (wr_q.size() == 0) begin
                n_fail++;
                $display("FAIL fb_write: got unexpected write addr=%h data=%h, required none",
                         fb_wr_addr, fb_wr_data);
            end else begin
                wexp = wr_q.pop_front();
                if ({fb_wr_addr, fb_wr_data} !== wexp) begin
                    n_fail++;
                    $display("FAIL fb_write: got addr=%h data=%h, required addr=%h data=%h",
                             fb_wr_addr, fb_wr_data, wexp[20:4], wexp[3:0]);
                end
            end
        end
        if (rd_ack) begin
            n_tests++;
            if (ack_q.size() == 0) begin
                n_fail++;
                $display("FAIL rd_ack: got unexpected ack, required none");
            end else begin
                aexp = ack_q.pop_front();
                if ({rd_bank, rd_new, rd_valid, repeat_cnt} !== aexp) begin
                    n_fail++;
                    $display("FAIL rd_ack: got bank=%0d new=%b valid=%b rep=%0d, required bank=%0d new=%b valid=%b rep=%0d",
                             rd_bank, rd_new, rd_valid, repeat_cnt,
                             aexp[11:10], aexp[9], aexp[8], aexp[7:0]);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] pix(input logic [14:0] a);
        return a[3:0] ^ a[7:4] ^ a[11:8];
    endfunction

    task automatic px(input logic [1:0] bank, input logic [14:0] a, input bit expect_wr);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = pix(a);
        if (expect_wr) wr_q.push_back({bank, a, pix(a)});
        step();
        wr_en = 1'b0;
    endtask

    task automatic sof_px(input logic [1:0] bank);
        wr_sof  = 1'b1;
        wr_en   = 1'b1;
        wr_addr = '0;
        wr_data = 4'hA;
        wr_q.push_back({bank, 15'd0, 4'hA});
        step();
        wr_sof = 1'b0;
        wr_en  = 1'b0;
    endtask

    task automatic pixels(input logic [1:0] bank, input int first, input int last);
        for (int a = first; a <= last; a++) px(bank, 15'(a), 1'b1);
    endtask

    task automatic eof();
        wr_eof = 1'b1;
        step();
        wr_eof = 1'b0;
    endtask

    task automatic rd(input logic [1:0] bank, input logic nw, input logic vld,
                      input logic [7:0] rep);
        rd_req = 1'b1;
        ack_q.push_back({bank, nw, vld, rep});
        step();
        rd_req = 1'b0;
        step();
    endtask

    task automatic chk_reset_values();
        chk("rst_fb_wr", 32'(fb_wr), 0);
        chk("rst_fb_wr_addr", 32'(fb_wr_addr), 0);
        chk("rst_fb_wr_data", 32'(fb_wr_data), 0);
        chk("rst_rd_ack", 32'(rd_ack), 0);
        chk("rst_rd_valid", 32'(rd_valid), 0);
        chk("rst_rd_new", 32'(rd_new), 0);
        chk("rst_wr_bank", 32'(wr_bank), 0);
        chk("rst_rd_bank", 32'(rd_bank), 0);
        chk("rst_drop", 32'(drop_cnt), 0);
        chk("rst_repeat", 32'(repeat_cnt), 0);
        chk("rst_addr_err", 32'(addr_err), 0);
    endtask

    initial begin
        rd_addr = 15'h1234;
        step();
        step();
        chk_reset_values();
        chk("rd_addr_comb", 32'(fb_rd_addr), 32'({2'd0, 15'h1234}));
        rst_n = 1'b1;

        // Full frame into bank 0, then the reader takes it.
        sof_px(2'd0);
        chk("wr_bank_first", 32'(wr_bank), 0);
        pixels(2'd0, 1, 19199);
        eof();
        rd(2'd0, 1'b1, 1'b1, 8'd0);
        chk("rd_addr_bank0", 32'(fb_rd_addr), 32'({2'd0, 15'h1234}));

        // Two full frames while the reader holds bank 0: the first one is dropped.
        sof_px(2'd1);
        chk("wr_bank_second", 32'(wr_bank), 1);
        pixels(2'd1, 1, 19199);
        eof();
        sof_px(2'd2);
        chk("wr_bank_third", 32'(wr_bank), 2);
        pixels(2'd2, 1, 19199);
        eof();
        chk("drop_after_two", 32'(drop_cnt), 1);
        rd(2'd2, 1'b1, 1'b1, 8'd0);
        chk("rd_addr_bank2", 32'(fb_rd_addr), 32'({2'd2, 15'h1234}));

        // No new frame: the reader is re-served bank 2.
        rd(2'd2, 1'b0, 1'b1, 8'd1);

        // eof and rd_req in the same cycle hand over the just-completed bank.
        sof_px(2'd0);
        pixels(2'd0, 1, 7);
        wr_eof = 1'b1;
        rd_req = 1'b1;
        ack_q.push_back({2'd0, 1'b1, 1'b1, 8'd1});
        step();
        wr_eof = 1'b0;
        rd_req = 1'b0;
        step();
        chk("drop_after_same_cycle", 32'(drop_cnt), 1);

        // Out-of-range write is suppressed and sticky; sof mid-frame aborts without a drop.
        sof_px(2'd1);
        px(2'd1, 15'd19200, 1'b0);
        chk("addr_err_set", 32'(addr_err), 1);
        px(2'd1, 15'd5, 1'b1);
        sof_px(2'd1);
        chk("wr_bank_after_abort", 32'(wr_bank), 1);
        pixels(2'd1, 1, 3);
        eof();
        chk("drop_after_abort", 32'(drop_cnt), 1);
        chk("addr_err_sticky", 32'(addr_err), 1);
        rd(2'd1, 1'b1, 1'b1, 8'd1);

        // Reset in the middle of a frame; writes stay off until the next sof.
        sof_px(2'd0);
        pixels(2'd0, 1, 3);
        rst_n   = 1'b0;
        wr_en   = 1'b1;
        wr_addr = 15'd4;
        step();
        step();
        chk_reset_values();
        rst_n = 1'b1;
        for (int a = 5; a <= 8; a++) px(2'd0, 15'(a), 1'b0);
        chk("post_reset_rd_valid", 32'(rd_valid), 0);
        rd(2'd0, 1'b0, 1'b0, 8'd0);
        sof_px(2'd0);
        pixels(2'd0, 1, 2);
        eof();
        rd(2'd0, 1'b1, 1'b1, 8'd0);

        step();
        step();
        chk("wr_queue_drained", 32'(wr_q.size()), 0);
        chk("ack_queue_drained", 32'(ack_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
